// File: rtl/wb_reg_slave_pkg.sv
// Shared definitions for the Wishbone register slaves: FSM state encoding, byte-lane merge
// and the address-split constants used by the decoders.
package wb_reg_slave_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = WB_DATA_W / 8;
    // Above the register-index bits, this many bits select the RO bank; anything higher is unmapped.
    localparam int WB_RO_BANK_BITS = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    function automatic logic [WB_DATA_W-1:0] wb_sel_merge(
        input logic [WB_DATA_W-1:0] old_w,
        input logic [WB_DATA_W-1:0] new_w,
        input logic [WB_SEL_W-1:0]  sel
    );
        logic [WB_DATA_W-1:0] res;
        for (int k = 0; k < WB_SEL_W; k++) begin
            res[8*k +: 8] = sel[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_wait_fsm.sv
// Wait-state sequencer for wb_reg_slave: holds one outstanding request for WAIT_STATES cycles,
// then commits it and presents a single ack cycle. A dropped cycle line abandons the request.
module wb_wait_fsm
    import wb_reg_slave_pkg::*;
#(
    parameter int WAIT_STATES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_cyc,
    input  logic i_stb,
    output logic o_stall,
    output logic o_accept,
    output logic o_commit
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES);

    wb_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        o_stall  = 1'b0;
        o_accept = 1'b0;
        o_commit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_cyc && i_stb) begin
                    o_accept = 1'b1;
                    cnt_d    = CNT_LOAD;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                o_stall = 1'b1;
                if (!i_cyc) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd1) begin
                    // Commit on the same edge that raises ack.
                    o_commit = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                o_stall = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/wb_reg_slave.sv
// Wishbone pipelined register slave: NREGS RW control registers, NREGS RO status words, per-register
// write/read strobes. Define WB_REG_SLAVE_WAIT_EN to add WAIT_STATES cycles of response latency.
module wb_reg_slave
    import wb_reg_slave_pkg::*;
#(
    parameter int WB_ADDR_WIDTH = 30,
    parameter int NREGS         = 8,
    parameter int WAIT_STATES   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wb_cyc,
    input  logic                       i_wb_stb,
    output logic                       o_wb_stall,
    output logic                       o_wb_ack,
    input  logic                       i_wb_we,
    input  logic [WB_ADDR_WIDTH-1:0]   i_wb_addr,
    input  logic [WB_DATA_W-1:0]       i_wb_data,
    input  logic [WB_SEL_W-1:0]        i_wb_sel,
    output logic [WB_DATA_W-1:0]       o_wb_data,
    output logic [WB_DATA_W*NREGS-1:0] o_regs,
    input  logic [WB_DATA_W*NREGS-1:0] i_ro,
    output logic [NREGS-1:0]           o_wr_pulse,
    output logic [NREGS-1:0]           o_rd_pulse
);

    localparam int IDX_W = $clog2(NREGS);

    logic                     commit;
    logic                     req_we;
    logic [WB_ADDR_WIDTH-1:0] req_addr;
    logic [WB_DATA_W-1:0]     req_data;
    logic [WB_SEL_W-1:0]      req_sel;

`ifdef WB_REG_SLAVE_WAIT_EN
    logic                     accept;
    logic                     req_we_q;
    logic [WB_ADDR_WIDTH-1:0] req_addr_q;
    logic [WB_DATA_W-1:0]     req_data_q;
    logic [WB_SEL_W-1:0]      req_sel_q;

    wb_wait_fsm #(.WAIT_STATES(WAIT_STATES)) u_wait_fsm (
        .clk      (clk),
        .rst      (rst),
        .i_cyc    (i_wb_cyc),
        .i_stb    (i_wb_stb),
        .o_stall  (o_wb_stall),
        .o_accept (accept),
        .o_commit (commit)
    );

    // Request is held from accept to commit; the FSM alone decides whether it is used.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_we_q   <= i_wb_we;
            req_addr_q <= i_wb_addr;
            req_data_q <= i_wb_data;
            req_sel_q  <= i_wb_sel;
        end
    end

    assign req_we   = req_we_q;
    assign req_addr = req_addr_q;
    assign req_data = req_data_q;
    assign req_sel  = req_sel_q;
`else
    logic unused_wait_cfg;
    assign unused_wait_cfg = (WAIT_STATES != 0);

    assign o_wb_stall = 1'b0;
    assign commit     = i_wb_cyc & i_wb_stb;
    assign req_we     = i_wb_we;
    assign req_addr   = i_wb_addr;
    assign req_data   = i_wb_data;
    assign req_sel    = i_wb_sel;
`endif

    logic [IDX_W-1:0] req_idx;
    logic             req_ro;
    logic             req_mapped;

    assign req_idx    = req_addr[IDX_W-1:0];
    assign req_ro     = req_addr[IDX_W];
    assign req_mapped = (req_addr >> (IDX_W + WB_RO_BANK_BITS)) == '0;

    logic [WB_DATA_W-1:0] regs_q [NREGS];
    logic [WB_DATA_W-1:0] regs_d [NREGS];
    logic [WB_DATA_W-1:0] ro_w   [NREGS];
    logic [WB_DATA_W-1:0] rdata_q, rdata_d;
    logic [NREGS-1:0]     wr_pulse_q, wr_pulse_d;
    logic [NREGS-1:0]     rd_pulse_q, rd_pulse_d;
    logic                 ack_q;

    for (genvar g = 0; g < NREGS; g++) begin : g_pack
        assign o_regs[WB_DATA_W*g +: WB_DATA_W] = regs_q[g];
        assign ro_w[g] = i_ro[WB_DATA_W*g +: WB_DATA_W];
    end

    always_comb begin
        regs_d     = regs_q;
        rdata_d    = '0;
        wr_pulse_d = '0;
        rd_pulse_d = '0;
        if (commit && req_mapped) begin
            if (req_ro) begin
                // RO writes are acked but have no effect.
                if (!req_we) begin
                    rdata_d             = ro_w[req_idx];
                    rd_pulse_d[req_idx] = 1'b1;
                end
            end else if (req_we) begin
                regs_d[req_idx]     = wb_sel_merge(regs_q[req_idx], req_data, req_sel);
                wr_pulse_d[req_idx] = 1'b1;
            end else begin
                rdata_d = regs_q[req_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q     <= '{default: '0};
            rdata_q    <= '0;
            wr_pulse_q <= '0;
            rd_pulse_q <= '0;
            ack_q      <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            rdata_q    <= rdata_d;
            wr_pulse_q <= wr_pulse_d;
            rd_pulse_q <= rd_pulse_d;
            ack_q      <= commit;
        end
    end

    // A master that has already dropped the cycle never sees a late ack.
    assign o_wb_ack   = ack_q & i_wb_cyc;
    assign o_wb_data  = o_wb_ack ? rdata_q : '0;
    assign o_wr_pulse = wr_pulse_q;
    assign o_rd_pulse = rd_pulse_q;

endmodule

// File: tb/tb_wb_reg_slave.sv
// Bench for wb_reg_slave: directed vector table, hand-written timing sequences and randomized
// transactions against a word-array register model.
module tb_wb_reg_slave;

    localparam int AW = 30;
    localparam int NR = 8;
    localparam int WS = 2;
    localparam int DW = 32;
`ifdef WB_REG_SLAVE_WAIT_EN
    localparam int LAT = 1 + WS;
`else
    localparam int LAT = 1;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cyc = 1'b0;
    logic            stb = 1'b0;
    logic            we = 1'b0;
    logic [AW-1:0]   addr = '0;
    logic [31:0]     wdata = '0;
    logic [3:0]      sel = '0;
    logic            stall, ack;
    logic [31:0]     rdata;
    logic [DW*NR-1:0] regs;
    logic [DW*NR-1:0] ro = '0;
    logic [NR-1:0]   wrp, rdp;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mregs [NR];
    logic [31:0] mro   [NR];

    always #5 clk = ~clk;

    wb_reg_slave #(.WB_ADDR_WIDTH(AW), .NREGS(NR), .WAIT_STATES(WS)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_wb_cyc   (cyc),
        .i_wb_stb   (stb),
        .o_wb_stall (stall),
        .o_wb_ack   (ack),
        .i_wb_we    (we),
        .i_wb_addr  (addr),
        .i_wb_data  (wdata),
        .i_wb_sel   (sel),
        .o_wb_data  (rdata),
        .o_regs     (regs),
        .i_ro       (ro),
        .o_wr_pulse (wrp),
        .o_rd_pulse (rdp)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW*NR-1:0] model_flat();
        logic [DW*NR-1:0] f;
        for (int i = 0; i < NR; i++) f[32*i +: 32] = mregs[i];
        return f;
    endfunction

    task automatic load_ro();
        for (int i = 0; i < NR; i++) ro[32*i +: 32] = mro[i];
    endtask

    task automatic clear_model();
        for (int i = 0; i < NR; i++) mregs[i] = '0;
    endtask

    // Map: words 0..NR-1 are RW registers, NR..2NR-1 are RO words, anything else is unmapped.
    task automatic model_xact(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                              input logic [3:0] s, output logic [31:0] e_data,
                              output logic [NR-1:0] e_wr, output logic [NR-1:0] e_rd);
        int i;
        logic [31:0] mask;
        e_data = '0;
        e_wr   = '0;
        e_rd   = '0;
        mask   = '0;
        if (a < AW'(NR)) begin
            i = int'(a);
            if (w) begin
                for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
                mregs[i] = (mregs[i] & ~mask) | (d & mask);
                e_wr = NR'(1) << i;
            end else begin
                e_data = mregs[i];
            end
        end else if (a < AW'(2 * NR)) begin
            i = int'(a) - NR;
            if (!w) begin
                e_data = mro[i];
                e_rd   = NR'(1) << i;
            end
        end
    endtask

    task automatic run_xact(input string tag, input logic w, input logic [AW-1:0] a,
                            input logic [31:0] d, input logic [3:0] s, input logic [31:0] e_data,
                            input logic [NR-1:0] e_wr, input logic [NR-1:0] e_rd);
        int waited;
        int lat;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
        waited = 0;
        while (stall && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        @(negedge clk);
        stb = 1'b0; we = 1'b0;
        lat = 1;
        while (!ack && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, lat, LAT);
        check({tag, ".data"}, rdata, e_data);
        check({tag, ".wrp"}, wrp, e_wr);
        check({tag, ".rdp"}, rdp, e_rd);
        check({tag, ".regs"}, regs, model_flat());
        cyc = 1'b0;
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    sel;
        logic [31:0]   e_data;
        logic [NR-1:0] e_wr;
        logic [NR-1:0] e_rd;
    } vec_t;

    vec_t vecs [17];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]   ed;
        logic [NR-1:0] ew, er;
        logic          rw;
        logic [AW-1:0] ra;
        logic [31:0]   rd;
        logic [3:0]    rs;
        int            k;

        vecs[0]  = '{1'b1, AW'(3),     32'hDEADBEEF, 4'hF, 32'h0,        8'h08, 8'h00};
        vecs[1]  = '{1'b0, AW'(3),     32'h0,        4'hF, 32'hDEADBEEF, 8'h00, 8'h00};
        vecs[2]  = '{1'b1, AW'(0),     32'h11223344, 4'hF, 32'h0,        8'h01, 8'h00};
        vecs[3]  = '{1'b1, AW'(0),     32'hAABBCCDD, 4'h5, 32'h0,        8'h01, 8'h00};
        vecs[4]  = '{1'b0, AW'(0),     32'h0,        4'hF, 32'h11BB33DD, 8'h00, 8'h00};
        vecs[5]  = '{1'b0, AW'(13),    32'h0,        4'hF, 32'h0000CAFE, 8'h00, 8'h20};
        vecs[6]  = '{1'b1, AW'(13),    32'h12345678, 4'hF, 32'h0,        8'h00, 8'h00};
        vecs[7]  = '{1'b0, AW'('h100), 32'h0,        4'hF, 32'h0,        8'h00, 8'h00};
        vecs[8]  = '{1'b1, AW'('h100), 32'hFFFFFFFF, 4'hF, 32'h0,        8'h00, 8'h00};
        vecs[9]  = '{1'b1, AW'(2),     32'hFFFFFFFF, 4'h0, 32'h0,        8'h04, 8'h00};
        vecs[10] = '{1'b0, AW'(2),     32'h0,        4'hF, 32'h0,        8'h00, 8'h00};
        vecs[11] = '{1'b0, AW'(8),     32'h0,        4'hF, 32'hA5A50000, 8'h00, 8'h01};
        vecs[12] = '{1'b1, AW'(7),     32'hCAFEF00D, 4'hA, 32'h0,        8'h80, 8'h00};
        vecs[13] = '{1'b0, AW'(7),     32'h0,        4'hF, 32'hCA00F000, 8'h00, 8'h00};
        vecs[14] = '{1'b0, AW'(16),    32'h0,        4'hF, 32'h0,        8'h00, 8'h00};
        vecs[15] = '{1'b0, AW'(15),    32'h0,        4'hF, 32'hA5A50007, 8'h00, 8'h80};
        vecs[16] = '{1'b0, AW'(3),     32'h0,        4'h0, 32'hDEADBEEF, 8'h00, 8'h00};

        for (int i = 0; i < NR; i++) mro[i] = 32'hA5A50000 | 32'(i);
        mro[5] = 32'h0000CAFE;
        load_ro();
        clear_model();

        // Reset state, with cyc high so a stray ack would be visible.
        cyc = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.ack", ack, 1'b0);
        check("rst.data", rdata, 32'h0);
        check("rst.stall", stall, 1'b0);
        check("rst.regs", regs, '0);
        check("rst.wrp", wrp, '0);
        check("rst.rdp", rdp, '0);
        rst = 1'b0;
        cyc = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            model_xact(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel, ed, ew, er);
            run_xact($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel,
                     vecs[i].e_data, vecs[i].e_wr, vecs[i].e_rd);
        end

`ifndef WB_REG_SLAVE_WAIT_EN
        // Back-to-back write then read of the same register.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = AW'(1); wdata = 32'h12345678; sel = 4'hF;
        mregs[1] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        check("b2b.wack", ack, 1'b1);
        check("b2b.wrp", wrp, 8'h02);
        check("b2b.regs", regs, model_flat());
        we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("b2b.rack", ack, 1'b1);
        check("b2b.rdata", rdata, 32'h12345678);
        stb = 1'b0;
        @(negedge clk);
        check("b2b.idle", ack, 1'b0);
        cyc = 1'b0;

        // Ack suppressed when cyc is already low in the response cycle.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = AW'(3);
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        #1;
        check("cycdrop.ack", ack, 1'b0);
        check("cycdrop.data", rdata, 32'h0);
`else
        // Wait states: stall for three cycles, ack in the third, held request accepted next.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = AW'(3); sel = 4'hF;
        @(posedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("ws.stall%0d", c), stall, 1'b1);
            check($sformatf("ws.ack%0d", c), ack, c == 3);
            if (c == 1) begin
                we = 1'b1; addr = AW'(6); wdata = 32'h0BADF00D;
            end
            if (c == 3) check("ws.rdata", rdata, mregs[3]);
        end
        @(negedge clk);
        check("ws.stall4", stall, 1'b0);
        check("ws.ack4", ack, 1'b0);
        @(posedge clk);
        @(negedge clk);
        stb = 1'b0; we = 1'b0;
        mregs[6] = 32'h0BADF00D;
        k = 1;
        while (!ack && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ws.b.lat", k, 3);
        check("ws.b.wrp", wrp, 8'h40);
        check("ws.b.regs", regs, model_flat());
        cyc = 1'b0;

        // Abort: cyc dropped in WAIT.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = AW'(5); wdata = 32'h55AA55AA; sel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("abort.stall", stall, 1'b0);
        check("abort.ack", ack, 1'b0);
        check("abort.wrp", wrp, '0);
        check("abort.regs", regs, model_flat());
        cyc = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("abort.noack%0d", c), ack, 1'b0);
        end
        cyc = 1'b0;

        // Reset in the middle of WAIT.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = AW'(1); wdata = 32'h77777777; sel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        stb = 1'b0; we = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstwait.ack", ack, 1'b0);
        check("rstwait.stall", stall, 1'b0);
        check("rstwait.regs", regs, '0);
        rst = 1'b0;
        clear_model();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("rstwait.noack%0d", c), ack, 1'b0);
        end
        cyc = 1'b0;
`endif

        // Randomized traffic against the model.
        for (int t = 0; t < 150; t++) begin
            rw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8) ra = AW'($urandom_range(0, 2 * NR - 1));
            else ra = AW'(2 * NR + $urandom_range(0, 4000));
            rd = $urandom;
            rs = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                mro[$urandom_range(0, NR - 1)] = $urandom;
                load_ro();
            end
            model_xact(rw, ra, rd, rs, ed, ew, er);
            run_xact($sformatf("rnd%0d", t), rw, ra, rd, rs, ed, ew, er);
        end

        // Reset clears the register bank.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("finrst.regs", regs, '0);
        check("finrst.ack", ack, 1'b0);
        rst = 1'b0;
        clear_model();
        model_xact(1'b0, AW'(3), 32'h0, 4'hF, ed, ew, er);
        run_xact("postrst", 1'b0, AW'(3), 32'h0, 4'hF, ed, ew, er);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
